// File: rtl/reg_file_sb_pkg.sv
// regfile_pkg: shared constants for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   ZERO_REG                : hardwired-zero register index
//   cnt_w()                 : width of busy_cnt for a given address width
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  // Holds 0..2**aw; one bit wider than the address.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback/debug bus of the register file.
//   master : decode + writeback side (drives addresses, write, reserve)
//   slave  : register file side (drives read data, busy flags, counters)
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0]               ra;
  logic [NREAD*DATA_W-1:0]               rd;
  logic [NREAD-1:0]                      rbusy;
  logic                                  we;
  logic [ADDR_W-1:0]                     wa;
  logic [DATA_W-1:0]                     wd;
  logic                                  rsv_en;
  logic [ADDR_W-1:0]                     rsv_addr;
  logic [regfile_pkg::cnt_w(ADDR_W)-1:0] busy_cnt;
  logic                                  rsv_err;
  logic [ADDR_W-1:0]                     dbg_ra;
  logic [DATA_W-1:0]                     dbg_rd;

  modport master (
    output ra, we, wa, wd, rsv_en, rsv_addr, dbg_ra,
    input  rd, rbusy, busy_cnt, rsv_err, dbg_rd
  );
  modport slave (
    input  ra, we, wa, wd, rsv_en, rsv_addr, dbg_ra,
    output rd, rbusy, busy_cnt, rsv_err, dbg_rd
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits for RAW hazard detection.
//   we/wa          : writeback release (clears busy[wa])
//   rsv_en/rsv_addr: decode reserve (sets busy[rsv_addr]); reserve wins a
//                    same-address collision with the release
//   ra             : read addresses; rbusy is the raw busy bit per port
//   busy_cnt       : registered popcount of busy bits
//   rsv_err        : sticky, set when reserving an already-busy register
// Register 0 is never marked busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             wa,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic [NREAD*ADDR_W-1:0]       ra,
  output logic [NREAD-1:0]              rbusy,
  output logic [cnt_w(ADDR_W)-1:0]      busy_cnt,
  output logic                          rsv_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = cnt_w(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA  = ADDR_W'(ZERO_REG);
  localparam logic [CW-1:0]     ONE = CW'(1);

  logic [DEPTH-1:0] busy;
  logic set, clr, inc, dec;

  assign set = rsv_en && (rsv_addr != ZA);
  assign clr = we && (wa != ZA);
  // Count tracks actual 0->1 and 1->0 transitions of the busy vector, so it
  // equals the popcount without summing all bits.
  assign inc = set && !busy[rsv_addr];
  assign dec = clr && busy[wa] && !(set && (rsv_addr == wa));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      if (clr) busy[wa] <= 1'b0;
      // Later assignment wins on the same index: reserve beats release.
      if (set) busy[rsv_addr] <= 1'b1;
      if (set && busy[rsv_addr]) rsv_err <= 1'b1;
      case ({inc, dec})
        2'b10:   busy_cnt <= busy_cnt + ONE;
        2'b01:   busy_cnt <= busy_cnt - ONE;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rb
    logic [ADDR_W-1:0] a;
    assign a        = ra[i*ADDR_W +: ADDR_W];
    assign rbusy[i] = busy[a] && (a != ZA);
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with scoreboard, hardwired r0
// and a debug read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears all state)
//   bus        : reg_file_sb_if.slave (read ports, writeback, reserve, debug)
// Optional build macro REGFILE_BYPASS_EN: same-cycle write data is forwarded
// onto matching read ports and their busy flag is masked unless the same
// register is being reserved in that cycle. dbg_rd is never forwarded.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NREAD-1:0]  sb_rbusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (bus.we && (bus.wa != ZA)) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .NREAD(NREAD)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.we),
    .wa       (bus.wa),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .ra       (bus.ra),
    .rbusy    (sb_rbusy),
    .busy_cnt (bus.busy_cnt),
    .rsv_err  (bus.rsv_err)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] stored;
    assign a      = bus.ra[i*ADDR_W +: ADDR_W];
    assign stored = (a == ZA) ? '0 : mem[a];
`ifdef REGFILE_BYPASS_EN
    logic fwd, rsv_hit;
    assign fwd     = bus.we && (bus.wa == a) && (a != ZA);
    assign rsv_hit = bus.rsv_en && (bus.rsv_addr == a);
    assign bus.rd[i*DATA_W +: DATA_W] = fwd ? bus.wd : stored;
    assign bus.rbusy[i] = sb_rbusy[i] && !(fwd && !rsv_hit);
`else
    assign bus.rd[i*DATA_W +: DATA_W] = stored;
    assign bus.rbusy[i] = sb_rbusy[i];
`endif
  end

  assign bus.dbg_rd = (bus.dbg_ra == ZA) ? '0 : mem[bus.dbg_ra];
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0, n_err = 0;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus();
  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state straight from the rules.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_err;

  function automatic void m_reset();
    for (int k = 0; k < DEPTH; k++) begin m_reg[k] = '0; m_busy[k] = 0; end
    m_err = 0;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) c += m_busy[k];
    return c;
  endfunction

  function automatic logic [AW-1:0] port_a(int i);
    return bus.ra[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] m_rd(int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && int'(bus.wa) == a) return bus.wd;
`endif
    return m_reg[a];
  endfunction

  function automatic bit m_rbusy(int a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && int'(bus.wa) == a && !(bus.rsv_en && int'(bus.rsv_addr) == a)) return 0;
`endif
    return m_busy[a];
  endfunction

  function automatic void m_edge();
    int w = int'(bus.wa), r = int'(bus.rsv_addr);
    if (bus.rsv_en && r != 0 && m_busy[r]) m_err = 1;
    if (bus.we && w != 0) begin m_reg[w] = bus.wd; m_busy[w] = 0; end
    if (bus.rsv_en && r != 0) m_busy[r] = 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s rd%0d", tag, i), 64'(bus.rd[i*DW +: DW]), 64'(m_rd(int'(port_a(i)))));
      chk($sformatf("%s rbusy%0d", tag, i), 64'(bus.rbusy[i]), 64'(m_rbusy(int'(port_a(i)))));
    end
    chk({tag, " busy_cnt"}, 64'(bus.busy_cnt), 64'(m_cnt()));
    chk({tag, " rsv_err"}, 64'(bus.rsv_err), 64'(m_err));
    chk({tag, " dbg_rd"}, 64'(bus.dbg_rd), 64'(bus.dbg_ra == 0 ? '0 : m_reg[bus.dbg_ra]));
  endtask

  // Check combinational view before the edge, then advance model and DUT.
  task automatic step(input string tag);
    @(negedge clk);
    chk_all(tag);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit rs, input int rsa);
    bus.we = we; bus.wa = AW'(wa); bus.wd = wd;
    bus.rsv_en = rs; bus.rsv_addr = AW'(rsa);
  endtask

  task automatic set_ra(input int a0, input int a1);
    bus.ra = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    m_reset();
    drive(0, 0, '0, 0, 0); set_ra(5, 0); bus.dbg_ra = AW'(5);
    #1 rst_n = 1'b0;
    #2 chk_all("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-operation: stored data and pending reservation both vanish.
    drive(1, 5, 32'hDEAD_BEEF, 1, 9);        step("wr r5");
    drive(0, 0, '0, 0, 0); set_ra(5, 9);     step("rd r5");
    #2 rst_n = 1'b0;
    #1;
    chk("async rd r5", 64'(bus.rd[DW-1:0]), 64'h0);
    chk("async rbusy r9", 64'(bus.rbusy[1]), 64'h0);
    chk("async busy_cnt", 64'(bus.busy_cnt), 64'h0);
    chk("async dbg_rd", 64'(bus.dbg_rd), 64'h0);
    m_reset();
    #1 rst_n = 1'b1;

    // Zero register: writes and reserves ignored.
    set_ra(0, 0); bus.dbg_ra = '0;
    drive(1, 0, 32'h1234, 1, 0);             step("zero wr");
    drive(0, 0, '0, 0, 0);                   step("zero rd");
    chk("zero busy_cnt", 64'(bus.busy_cnt), 64'h0);

    // Scoreboard reserve/release on r3.
    set_ra(3, 0); bus.dbg_ra = AW'(3);
    drive(0, 0, '0, 1, 3);                   step("rsv r3");
    drive(0, 0, '0, 0, 0);                   step("r3 busy a");
    chk("r3 rbusy", 64'(bus.rbusy[0]), 64'h1);
    chk("r3 cnt", 64'(bus.busy_cnt), 64'h1);
    step("r3 busy b");
    drive(1, 3, 32'h55, 0, 0);               step("wr r3");
    drive(0, 0, '0, 0, 0);                   step("r3 done");
    chk("r3 rd", 64'(bus.rd[DW-1:0]), 64'h55);
    chk("r3 cnt0", 64'(bus.busy_cnt), 64'h0);

    // Same-cycle write/read of r7 (bypass dependent).
    set_ra(7, 7); bus.dbg_ra = AW'(7);
    drive(0, 0, '0, 1, 7);                   step("rsv r7");
    drive(1, 7, 32'hA5A5_A5A5, 0, 0);        step("byp r7");
    drive(0, 0, '0, 0, 0);                   step("r7 next");
    chk("r7 rd next", 64'(bus.rd[DW-1:0]), 64'hA5A5_A5A5);

    // Collision on busy r4: reserve wins, error is sticky.
    set_ra(4, 0); bus.dbg_ra = AW'(4);
    drive(0, 0, '0, 1, 4);                   step("rsv r4");
    drive(1, 4, 32'h77, 1, 4);               step("coll r4");
    drive(0, 0, '0, 0, 0);                   step("coll after");
    chk("coll rd", 64'(bus.rd[DW-1:0]), 64'h77);
    chk("coll rbusy", 64'(bus.rbusy[0]), 64'h1);
    chk("coll cnt", 64'(bus.busy_cnt), 64'h1);
    chk("coll err", 64'(bus.rsv_err), 64'h1);
    drive(1, 4, 32'h78, 0, 0);               step("rel r4");

    // Fill and drain every nonzero register.
    for (int r = 1; r < DEPTH; r++) begin
      drive(0, 0, '0, 1, r); set_ra(r, r - 1); step("fill");
    end
    drive(0, 0, '0, 0, 0);                   step("full");
    chk("full cnt", 64'(bus.busy_cnt), 64'd31);
    for (int r = 1; r < DEPTH; r++) begin
      drive(1, r, DW'(r * 3), 0, 0); set_ra(r, 0); step("drain");
    end
    drive(0, 0, '0, 0, 0);                   step("empty");
    chk("empty cnt", 64'(bus.busy_cnt), 64'h0);
    chk("sticky err", 64'(bus.rsv_err), 64'h1);

    // Random traffic against the model; small address range raises collisions.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7));
      set_ra($urandom_range(0, 7), $urandom_range(0, 7));
      bus.dbg_ra = AW'($urandom_range(0, 7));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
